// File: rtl/decode_exec_unit_pkg.sv
// Shared opcode/funct constants and control-field encodings for the decode/execute stage.
package decode_exec_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ALU_ADDU = 2'b00,
        ALU_SUBU = 2'b01,
        ALU_OR   = 2'b10,
        ALU_SLT  = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pcSrc_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_R31 = 2'b10
    } regDst_e;

    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_DM    = 2'b01,
        WB_PC4   = 2'b10,
        WB_UNUSED = 2'b11
    } regWriteSrc_e;

endpackage

// File: rtl/decode_exec_alu.sv
// Combinational 32-bit ALU (addu/subu/or/slt) with a zero flag on every operation.
module decode_exec_alu
    import decode_exec_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aluOp_e      op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADDU: result = a + b;
            ALU_SUBU: result = a - b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/decode_exec_unit.sv
// Single-cycle MIPS decode, immediate extension and ALU; the only state is a
// sticky flag recording that an unsupported instruction reached this stage.
module decode_exec_unit
    import decode_exec_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Inst,
    input  logic [31:0] GPRReadData1,
    input  logic [31:0] GPRReadData2,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    output logic [31:0] SignExtend,
    output logic [31:0] UnsignExtend,
    output logic [1:0]  PCSrc,
    output logic [1:0]  RegWriteSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  ALUOperation,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [31:0] ALUResult,
    output logic        ALUZero,
    output logic        IllegalInst
);

    logic [5:0]   opcode;
    logic [5:0]   funct;
    pcSrc_e       pcSrc;
    regWriteSrc_e wbSrc;
    regDst_e      regDst;
    aluOp_e       aluOp;
    logic         regWrite;
    logic         memWrite;
    logic         aluSrc;
    logic         illegal;
    logic [31:0]  aluB;

    assign opcode = Inst[31:26];
    assign funct  = Inst[5:0];
    assign rs     = Inst[25:21];
    assign rt     = Inst[20:16];
    assign rd     = Inst[15:11];
    assign imm16  = Inst[15:0];
    assign imm26  = Inst[25:0];

    assign SignExtend   = {{16{imm16[15]}}, imm16};
    assign UnsignExtend = {16'd0, imm16};

    // Unsupported encodings leave every control at its default, so they cause no writes.
    always_comb begin
        pcSrc    = PC_PLUS4;
        wbSrc    = WB_ALU;
        regDst   = DST_RT;
        aluOp    = ALU_ADDU;
        regWrite = 1'b0;
        memWrite = 1'b0;
        aluSrc   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin regWrite = 1'b1; regDst = DST_RD; aluOp = ALU_ADDU; end
                    FN_SUBU: begin regWrite = 1'b1; regDst = DST_RD; aluOp = ALU_SUBU; end
                    FN_OR:   begin regWrite = 1'b1; regDst = DST_RD; aluOp = ALU_OR;   end
                    FN_SLT:  begin regWrite = 1'b1; regDst = DST_RD; aluOp = ALU_SLT;  end
                    FN_JR:   pcSrc = PC_REG;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDIU: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
            end
            OP_LW: begin
                regWrite = 1'b1;
                wbSrc    = WB_DM;
                aluSrc   = 1'b1;
            end
            OP_SW: begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
            end
            OP_BEQ: begin
                aluOp = ALU_SUBU;
                pcSrc = PC_BRANCH;
            end
            OP_J:   pcSrc = PC_JUMP;
            OP_JAL: begin
                pcSrc    = PC_JUMP;
                regWrite = 1'b1;
                regDst   = DST_R31;
                wbSrc    = WB_PC4;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign PCSrc        = pcSrc;
    assign RegWriteSrc  = wbSrc;
    assign RegDst       = regDst;
    assign ALUOperation = aluOp;
    assign RegWrite     = regWrite;
    assign MemWrite     = memWrite;
    assign ALUSrc       = aluSrc;

    assign aluB = aluSrc ? SignExtend : GPRReadData2;

    decode_exec_alu uAlu (
        .a      (GPRReadData1),
        .b      (aluB),
        .op     (aluOp),
        .result (ALUResult),
        .zero   (ALUZero)
    );

    always_ff @(posedge CLK) begin
        if (Reset)
            IllegalInst <= 1'b0;
        else if (illegal)
            IllegalInst <= 1'b1;
    end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed bench for decode_exec_unit: each task drives one scenario and checks inline.
module tb_decode_exec_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] Inst;
    logic [31:0] GPRReadData1;
    logic [31:0] GPRReadData2;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] SignExtend, UnsignExtend;
    logic [1:0]  PCSrc, RegWriteSrc, ALUOperation, RegDst;
    logic        RegWrite, MemWrite, ALUSrc;
    logic [31:0] ALUResult;
    logic        ALUZero, IllegalInst;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    // {PCSrc, RegWriteSrc, RegWrite, MemWrite, ALUOperation, RegDst, ALUSrc}
    logic [10:0] ctrl;
    assign ctrl = {PCSrc, RegWriteSrc, RegWrite, MemWrite, ALUOperation, RegDst, ALUSrc};

    decode_exec_unit dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Inst         (Inst),
        .GPRReadData1 (GPRReadData1),
        .GPRReadData2 (GPRReadData2),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm16        (imm16),
        .imm26        (imm26),
        .SignExtend   (SignExtend),
        .UnsignExtend (UnsignExtend),
        .PCSrc        (PCSrc),
        .RegWriteSrc  (RegWriteSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .ALUOperation (ALUOperation),
        .RegDst       (RegDst),
        .ALUSrc       (ALUSrc),
        .ALUResult    (ALUResult),
        .ALUZero      (ALUZero),
        .IllegalInst  (IllegalInst)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Inst = inst;
        GPRReadData1 = a;
        GPRReadData2 = b;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(32'h0000_0000, 32'd0, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (IllegalInst !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flag: got %b want 0", IllegalInst);
        end
        drive(32'h0085_1021, 32'd0, 32'd0);
        Reset = 1'b0;
    endtask

    task automatic test_addu();
        drive(32'h0085_1021, 32'h7FFF_FFFF, 32'd1);
        tests_run++;
        if (ALUResult !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL addu_result: got %h want 80000000", ALUResult);
        end
        tests_run++;
        if (ctrl !== {2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0}) begin
            tests_failed++;
            $display("FAIL addu_ctrl: got %b want 00001000010", ctrl);
        end
        tests_run++;
        if ({rs, rt, rd} !== {5'd4, 5'd5, 5'd2}) begin
            tests_failed++;
            $display("FAIL addu_fields: got rs=%0d rt=%0d rd=%0d want 4 5 2", rs, rt, rd);
        end
    endtask

    task automatic test_lw();
        drive(32'h8C88_FFFC, 32'h0000_0100, 32'h1234_5678);
        tests_run++;
        if (SignExtend !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL lw_sext: got %h want fffffffc", SignExtend);
        end
        tests_run++;
        if (UnsignExtend !== 32'h0000_FFFC) begin
            tests_failed++;
            $display("FAIL lw_zext: got %h want 0000fffc", UnsignExtend);
        end
        tests_run++;
        if (ALUResult !== 32'h0000_00FC) begin
            tests_failed++;
            $display("FAIL lw_result: got %h want 000000fc", ALUResult);
        end
        tests_run++;
        if (ctrl !== {2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1}) begin
            tests_failed++;
            $display("FAIL lw_ctrl: got %b want 00011000001", ctrl);
        end
    endtask

    task automatic test_sw_addiu_j();
        drive(32'hAC88_0010, 32'h0000_1000, 32'hDEAD_BEEF);
        tests_run++;
        if (ctrl !== {2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1} || ALUResult !== 32'h0000_1010) begin
            tests_failed++;
            $display("FAIL sw: got ctrl=%b res=%h want 00000100001 00001010", ctrl, ALUResult);
        end
        drive(32'h2488_8000, 32'h0001_0000, 32'h0000_0005);
        tests_run++;
        if (ctrl !== {2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1} || ALUResult !== 32'h0000_8000) begin
            tests_failed++;
            $display("FAIL addiu: got ctrl=%b res=%h want 00001000001 00008000", ctrl, ALUResult);
        end
        drive(32'h0800_0123, 32'd0, 32'd0);
        tests_run++;
        if (ctrl !== {2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL j_ctrl: got %b want 10000000000", ctrl);
        end
    endtask

    task automatic test_beq();
        drive(32'h1085_0003, 32'd5, 32'd5);
        tests_run++;
        if (ctrl !== {2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL beq_ctrl: got %b want 01000010000", ctrl);
        end
        tests_run++;
        if (ALUResult !== 32'd0 || ALUZero !== 1'b1) begin
            tests_failed++;
            $display("FAIL beq_equal: got res=%h zero=%b want 00000000 1", ALUResult, ALUZero);
        end
        drive(32'h1085_0003, 32'd5, 32'd6);
        tests_run++;
        if (ALUZero !== 1'b0 || ALUResult !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL beq_unequal: got res=%h zero=%b want ffffffff 0", ALUResult, ALUZero);
        end
    endtask

    task automatic test_slt();
        drive(32'h0085_102A, 32'hFFFF_FFFF, 32'd1);
        tests_run++;
        if (ALUResult !== 32'd1 || ALUOperation !== 2'b11) begin
            tests_failed++;
            $display("FAIL slt_neg_lt: got res=%h op=%b want 00000001 11", ALUResult, ALUOperation);
        end
        drive(32'h0085_102A, 32'd1, 32'hFFFF_FFFF);
        tests_run++;
        if (ALUResult !== 32'd0 || ALUZero !== 1'b1) begin
            tests_failed++;
            $display("FAIL slt_swapped: got res=%h zero=%b want 00000000 1", ALUResult, ALUZero);
        end
    endtask

    task automatic test_jumps();
        drive(32'h0C00_0010, 32'd0, 32'd0);
        tests_run++;
        if (ctrl !== {2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0}) begin
            tests_failed++;
            $display("FAIL jal_ctrl: got %b want 10101000100", ctrl);
        end
        tests_run++;
        if (imm26 !== 26'h10) begin
            tests_failed++;
            $display("FAIL jal_imm26: got %h want 0000010", imm26);
        end
        drive(32'h03E0_0008, 32'h0040_0000, 32'd0);
        tests_run++;
        if (ctrl !== {2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL jr_ctrl: got %b want 11000000000", ctrl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [31:0] as [4];
        logic [31:0] bs [4];
        logic [31:0] exp;
        insts = '{32'h0085_1023, 32'h0085_1025, 32'h0085_1023, 32'h0085_1021};
        as    = '{32'd3, 32'hF0F0_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        bs    = '{32'd5, 32'h0000_0F0F, 32'h1234_5678, 32'd1};
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hF0F0_0F0F);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            drive(insts[i], as[i], bs[i]);
            exp = exp_q.pop_front();
            tests_run++;
            if (ALUResult !== exp || ALUZero !== (exp == 32'd0)) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got res=%h zero=%b want %h", i, ALUResult, ALUZero, exp);
            end
        end
    endtask

    task automatic test_illegal();
        drive(32'hFC00_0000, 32'd7, 32'd9);
        tests_run++;
        if (ctrl !== 11'd0 || IllegalInst !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_ctrl: got ctrl=%b flag=%b want 0 0", ctrl, IllegalInst);
        end
        @(posedge CLK); #1;
        tests_run++;
        if (IllegalInst !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_set: got %b want 1", IllegalInst);
        end
        drive(32'h0085_1021, 32'd1, 32'd2);
        @(posedge CLK); #1;
        drive(32'h8C88_FFFC, 32'd1, 32'd2);
        @(posedge CLK); #1;
        tests_run++;
        if (IllegalInst !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got %b want 1", IllegalInst);
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        tests_run++;
        if (IllegalInst !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_clear: got %b want 0", IllegalInst);
        end
        drive(32'h0000_0000, 32'd0, 32'd0);
        tests_run++;
        if (ctrl !== 11'd0) begin
            tests_failed++;
            $display("FAIL sll_ctrl: got %b want 0", ctrl);
        end
        @(posedge CLK); #1;
        tests_run++;
        if (IllegalInst !== 1'b1) begin
            tests_failed++;
            $display("FAIL sll_sets_flag: got %b want 1", IllegalInst);
        end
        drive(32'h0000_003F, 32'd0, 32'd0);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        tests_run++;
        if (IllegalInst !== 1'b0 || ctrl !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_over_illegal: got flag=%b ctrl=%b want 0 0", IllegalInst, ctrl);
        end
        drive(32'h0085_1021, 32'd0, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        Inst = 32'h0085_1021;
        GPRReadData1 = 32'd0;
        GPRReadData2 = 32'd0;
        test_reset();
        test_addu();
        test_lw();
        test_sw_addiu_j();
        test_beq();
        test_slt();
        test_jumps();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
